// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//
// Interrupt and return sequencer for the 6502 core. It sits next to the
// execute FSM and owns the memory bus while a sequence is running. A one-cycle
// start resolves the request (soft reset, RTI, BRK, NMI, one of N_IRQ
// maskable IRQ lines, or nothing to do). It then performs the stack pushes or
// pulls and the vector fetch, and returns the new PC, status and stack pointer
// with a one-cycle done pulse.
//
// Parameters
//   N_IRQ        number of maskable level-sensitive IRQ lines (1..8), index 0 wins
//   RD_LAT       cycles from mem_read_en pulse to valid mem_data_in (>= 1)
//   EXT_VEC_BASE vector base for IRQ lines 1 and up (two bytes per line)
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   start                          one-cycle request from the execute FSM
//   soft_reset, is_rti, is_break   request qualifiers, sampled with start
//   nmi                            rising-edge non-maskable interrupt
//   irq[N_IRQ]                     level IRQs, sampled with start
//   pc_in, status_in, sp_in        CPU state, sampled with start
//   mem_addr, mem_data_out,
//   mem_write_en, mem_read_en      memory bus, all zero when not busy
//   mem_data_in                    read data, valid RD_LAT cycles after a read pulse
//   busy                           sequencer owns the bus
//   done                           one-cycle completion pulse
//   pc_out, status_out, sp_out     results, held until the next done
//   cause                          0 none, 1 reset, 2 rti, 3 brk, 4 nmi, 5 irq (done cycle)
//   irq_ack[N_IRQ]                 one-hot serviced IRQ line (done cycle)

module interrupt_sequencer #(
  parameter int          N_IRQ        = 4,
  parameter int          RD_LAT       = 2,
  parameter logic [15:0] EXT_VEC_BASE = 16'hFFE0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             soft_reset,
  input  logic             is_rti,
  input  logic             is_break,
  input  logic             nmi,
  input  logic [N_IRQ-1:0] irq,
  input  logic [15:0]      pc_in,
  input  logic [7:0]       status_in,
  input  logic [7:0]       sp_in,
  output logic [15:0]      mem_addr,
  output logic [7:0]       mem_data_out,
  output logic             mem_write_en,
  output logic             mem_read_en,
  input  logic [7:0]       mem_data_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pc_out,
  output logic [7:0]       status_out,
  output logic [7:0]       sp_out,
  output logic [2:0]       cause,
  output logic [N_IRQ-1:0] irq_ack
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_H,
    PUSH_L,
    PUSH_P,
    RD_REQ,
    RD_WAIT,
    FINISH
  } state_t;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_RESET = 3'd1;
  localparam logic [2:0] CAUSE_RTI   = 3'd2;
  localparam logic [2:0] CAUSE_BRK   = 3'd3;
  localparam logic [2:0] CAUSE_NMI   = 3'd4;
  localparam logic [2:0] CAUSE_IRQ   = 3'd5;

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t             r_state;
  state_t             w_nextState;

  logic               r_nmiPrev;
  logic               r_nmiPending;
  logic [15:0]        r_pc;
  logic [7:0]         r_status;
  logic [7:0]         r_sp;
  logic [7:0]         r_pushP;
  logic [15:0]        r_vec;
  logic [2:0]         r_cause;
  logic               r_isRti;
  logic [N_IRQ-1:0]   r_irqOneHot;
  logic [1:0]         r_rdIdx;
  logic [CNT_W-1:0]   r_waitCnt;
  logic [7:0]         r_pulledP;
  logic [7:0]         r_pcl;
  logic [15:0]        r_pcOut;
  logic [7:0]         r_statusOut;
  logic [7:0]         r_spOut;

  logic               w_nmiEdge;
  logic               w_accept;
  logic               w_irqAny;
  logic [N_IRQ-1:0]   w_irqOneHot;
  logic [15:0]        w_irqVec;
  logic [2:0]         w_cause;
  logic [15:0]        w_vec;
  logic [7:0]         w_pushP;
  logic [7:0]         w_stackRd;
  logic [15:0]        w_rdAddr;
  logic               w_capture;
  logic               w_lastRead;

  assign w_nmiEdge = nmi & ~r_nmiPrev;
  assign w_accept  = start & (r_state == IDLE);
  assign w_irqAny  = |irq;

  // Lowest-index asserted IRQ line and its vector. Scanning downward lets
  // the lowest index overwrite any higher one.
  always_comb begin
    w_irqOneHot = '0;
    w_irqVec    = 16'hFFFE;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (irq[k]) begin
        w_irqOneHot = N_IRQ'(1) << k;
        w_irqVec    = (k == 0) ? 16'hFFFE : EXT_VEC_BASE + 16'(2 * (k - 1));
      end
    end
  end

  // Request priority resolution. Maskable IRQs are blocked by the I flag.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (soft_reset)                         w_cause = CAUSE_RESET;
    else if (is_rti)                        w_cause = CAUSE_RTI;
    else if (is_break)                      w_cause = CAUSE_BRK;
    else if (r_nmiPending)                  w_cause = CAUSE_NMI;
    else if (!status_in[2] && w_irqAny)     w_cause = CAUSE_IRQ;
  end

  always_comb begin
    w_vec = 16'h0000;
    case (w_cause)
      CAUSE_RESET: w_vec = 16'hFFFC;
      CAUSE_BRK:   w_vec = 16'hFFFE;
      CAUSE_NMI:   w_vec = 16'hFFFA;
      CAUSE_IRQ:   w_vec = w_irqVec;
      default:     w_vec = 16'h0000;
    endcase
  end

  // BRK pushes B set; hardware interrupts push B clear. Bit 5 always set.
  assign w_pushP = is_break ? (status_in | 8'h30) : ((status_in | 8'h20) & 8'hEF);

  // RTI pulls walk upward from sp+1; vector reads walk from the vector base.
  assign w_stackRd  = r_sp + 8'd1 + 8'(r_rdIdx);
  assign w_rdAddr   = r_isRti ? {8'h01, w_stackRd} : r_vec + 16'(r_rdIdx);
  assign w_capture  = (r_state == RD_WAIT) && (r_waitCnt == CNT_W'(RD_LAT));
  assign w_lastRead = (r_rdIdx == (r_isRti ? 2'd2 : 2'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    mem_addr     = 16'h0000;
    mem_data_out = 8'h00;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (w_cause)
            CAUSE_NONE:              w_nextState = FINISH;
            CAUSE_RESET, CAUSE_RTI:  w_nextState = RD_REQ;
            default:                 w_nextState = PUSH_H;
          endcase
        end
      end
      PUSH_H: begin
        busy         = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = {8'h01, r_sp};
        mem_data_out = r_pc[15:8];
        w_nextState  = PUSH_L;
      end
      PUSH_L: begin
        busy         = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = {8'h01, r_sp - 8'd1};
        mem_data_out = r_pc[7:0];
        w_nextState  = PUSH_P;
      end
      PUSH_P: begin
        busy         = 1'b1;
        mem_write_en = 1'b1;
        mem_addr     = {8'h01, r_sp - 8'd2};
        mem_data_out = r_pushP;
        w_nextState  = RD_REQ;
      end
      RD_REQ: begin
        busy        = 1'b1;
        mem_read_en = 1'b1;
        mem_addr    = w_rdAddr;
        w_nextState = RD_WAIT;
      end
      RD_WAIT: begin
        busy     = 1'b1;
        mem_addr = w_rdAddr;
        if (w_capture) w_nextState = w_lastRead ? FINISH : RD_REQ;
      end
      FINISH: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, read sequencing and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nmiPrev    <= 1'b1;
      r_nmiPending <= 1'b0;
      r_pc         <= 16'h0000;
      r_status     <= 8'h00;
      r_sp         <= 8'h00;
      r_pushP      <= 8'h00;
      r_vec        <= 16'h0000;
      r_cause      <= CAUSE_NONE;
      r_isRti      <= 1'b0;
      r_irqOneHot  <= '0;
      r_rdIdx      <= 2'd0;
      r_waitCnt    <= '0;
      r_pulledP    <= 8'h00;
      r_pcl        <= 8'h00;
      r_pcOut      <= 16'h0000;
      r_statusOut  <= 8'h00;
      r_spOut      <= 8'hFF;
    end else begin
      r_nmiPrev <= nmi;
      // A fresh edge in the accepting cycle keeps the NMI pending.
      r_nmiPending <= w_nmiEdge | (r_nmiPending & ~(w_accept & (w_cause == CAUSE_NMI)));

      if (w_accept) begin
        r_pc        <= pc_in;
        r_status    <= status_in;
        r_sp        <= sp_in;
        r_pushP     <= w_pushP;
        r_vec       <= w_vec;
        r_cause     <= w_cause;
        r_isRti     <= (w_cause == CAUSE_RTI);
        r_irqOneHot <= (w_cause == CAUSE_IRQ) ? w_irqOneHot : '0;
        r_rdIdx     <= 2'd0;
        if (w_cause == CAUSE_NONE) begin
          r_pcOut     <= pc_in;
          r_statusOut <= status_in;
          r_spOut     <= sp_in;
        end
      end

      if (r_state == RD_REQ) r_waitCnt <= CNT_W'(1);
      else if ((r_state == RD_WAIT) && !w_capture) r_waitCnt <= r_waitCnt + CNT_W'(1);

      if (w_capture) begin
        if (w_lastRead) begin
          r_pcOut <= {mem_data_in, r_pcl};
          if (r_isRti) begin
            r_statusOut <= (r_pulledP & 8'hEF) | 8'h20;
            r_spOut     <= r_sp + 8'd3;
          end else begin
            r_statusOut <= r_status | 8'h04;
            r_spOut     <= r_sp - 8'd3;
          end
        end else begin
          if (r_isRti && (r_rdIdx == 2'd0)) r_pulledP <= mem_data_in;
          else                              r_pcl     <= mem_data_in;
          r_rdIdx <= r_rdIdx + 2'd1;
        end
      end
    end
  end

  assign pc_out     = r_pcOut;
  assign status_out = r_statusOut;
  assign sp_out     = r_spOut;
  assign cause      = (r_state == FINISH) ? r_cause : CAUSE_NONE;
  assign irq_ack    = (r_state == FINISH) ? r_irqOneHot : '0;

endmodule
